// File: rtl/mmix_bus_pkg.sv
// Shared types for the MMIX-to-Avalon bridge: access sizes and bridge FSM states.
package mmix_bus_pkg;

    typedef enum logic [1:0] {
        DS_BYTE  = 2'd0,
        DS_WYDE  = 2'd1,
        DS_TETRA = 2'd2,
        DS_OCTA  = 2'd3
    } datasize_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD_HI  = 3'd1,
        WAIT_HI = 3'd2,
        CMD_LO  = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } bridge_state_e;

endpackage

// File: rtl/mmix_lane_mux.sv
// Big-endian lane steering between the 64-bit MMIX data path and a 32-bit Avalon beat.
module mmix_lane_mux
    import mmix_bus_pkg::*;
(
    input  datasize_e   i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_hi_beat,
    input  logic [63:0] i_wdata,
    input  logic [31:0] i_avm_rdata,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_avm_wdata,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_byteenable = 4'b0000;
        o_avm_wdata  = 32'd0;
        o_rdata      = 32'd0;
        unique case (i_size)
            DS_BYTE: begin
                // Lane 0 (lowest byte address) lives in bits 31:24.
                o_byteenable = 4'b1000 >> i_lane;
                o_avm_wdata  = {4{i_wdata[7:0]}};
                unique case (i_lane)
                    2'd0:    o_rdata = {24'd0, i_avm_rdata[31:24]};
                    2'd1:    o_rdata = {24'd0, i_avm_rdata[23:16]};
                    2'd2:    o_rdata = {24'd0, i_avm_rdata[15:8]};
                    default: o_rdata = {24'd0, i_avm_rdata[7:0]};
                endcase
            end
            DS_WYDE: begin
                o_byteenable = i_lane[1] ? 4'b0011 : 4'b1100;
                o_avm_wdata  = {2{i_wdata[15:0]}};
                o_rdata      = i_lane[1] ? {16'd0, i_avm_rdata[15:0]}
                                         : {16'd0, i_avm_rdata[31:16]};
            end
            DS_TETRA: begin
                o_byteenable = 4'b1111;
                o_avm_wdata  = i_wdata[31:0];
                o_rdata      = i_avm_rdata;
            end
            default: begin
                o_byteenable = 4'b1111;
                o_avm_wdata  = i_hi_beat ? i_wdata[63:32] : i_wdata[31:0];
                o_rdata      = i_avm_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mmix_avm_bridge.sv
// Bridges single MMIX load/store requests onto a 32-bit big-endian Avalon-MM master,
// splitting octa accesses into a HI beat followed by a LO beat.
module mmix_avm_bridge
    import mmix_bus_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       mmix_address,
    input  logic [1:0]        mmix_datasize,
    input  logic              mmix_read,
    input  logic              mmix_write,
    input  logic [63:0]       mmix_writedata,
    output logic [63:0]       mmix_readdata,
    output logic              mmix_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    bridge_state_e     r_state;
    logic [ADDR_W-1:0] r_addr;
    datasize_e         r_size;
    logic              r_is_read;
    logic [63:0]       r_wdata;
    logic [31:0]       r_hi_word;
    logic [63:0]       r_rdata;

    logic              w_octa;
    logic              w_lo_beat;
    logic              w_cmd;
    logic [ADDR_W-1:0] w_addr_hi;
    logic [ADDR_W-1:0] w_addr_lo;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_rd_lane;

    generate
        if (ADDR_W < 64) begin : g_addr_trunc
            logic w_unused_addr;
            assign w_unused_addr = ^mmix_address[63:ADDR_W];
        end
    endgenerate

    assign w_octa    = (r_size == DS_OCTA);
    assign w_lo_beat = (r_state == CMD_LO);
    assign w_cmd     = (r_state == CMD_HI) || w_lo_beat;
    assign w_addr_hi = {r_addr[ADDR_W-1:3], r_addr[2] & ~w_octa, 2'b00};
    assign w_addr_lo = w_addr_hi + ADDR_W'(4);

    mmix_lane_mux u_lane_mux (
        .i_size       (r_size),
        .i_lane       (r_addr[1:0]),
        .i_hi_beat    (~w_lo_beat),
        .i_wdata      (r_wdata),
        .i_avm_rdata  (avm_readdata),
        .o_byteenable (w_be),
        .o_avm_wdata  (w_wd),
        .o_rdata      (w_rd_lane)
    );

    // Command outputs are gated so the bus reads all-zero whenever no command is offered.
    assign avm_address    = w_cmd ? (w_lo_beat ? w_addr_lo : w_addr_hi) : '0;
    assign avm_byteenable = w_cmd ? w_be : 4'b0000;
    assign avm_writedata  = w_cmd ? w_wd : 32'd0;
    assign avm_read       = w_cmd & r_is_read;
    assign avm_write      = w_cmd & ~r_is_read;
    assign mmix_done      = (r_state == DONE);
    assign mmix_readdata  = r_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_size    <= DS_BYTE;
            r_is_read <= 1'b0;
            r_wdata   <= 64'd0;
            r_hi_word <= 32'd0;
            r_rdata   <= 64'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (mmix_read || mmix_write) begin
                        r_addr    <= mmix_address[ADDR_W-1:0];
                        r_size    <= datasize_e'(mmix_datasize);
                        r_is_read <= mmix_read;
                        r_wdata   <= mmix_writedata;
                        r_state   <= CMD_HI;
                    end
                end
                CMD_HI: begin
                    if (!avm_waitrequest) begin
                        if (r_is_read)   r_state <= WAIT_HI;
                        else if (w_octa) r_state <= CMD_LO;
                        else             r_state <= DONE;
                    end
                end
                WAIT_HI: begin
                    if (avm_readdatavalid) begin
                        // Octa HI word is parked so mmix_readdata only changes once per load.
                        if (w_octa) begin
                            r_hi_word <= avm_readdata;
                            r_state   <= CMD_LO;
                        end else begin
                            r_rdata <= {32'd0, w_rd_lane};
                            r_state <= DONE;
                        end
                    end
                end
                CMD_LO: begin
                    if (!avm_waitrequest) r_state <= r_is_read ? WAIT_LO : DONE;
                end
                WAIT_LO: begin
                    if (avm_readdatavalid) begin
                        r_rdata <= {r_hi_word, avm_readdata};
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmix_avm_bridge.sv
// Directed plus randomized bench for mmix_avm_bridge against a byte-addressed memory model.
module tb_mmix_avm_bridge;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [63:0]       mmix_address;
    logic [1:0]        mmix_datasize;
    logic              mmix_read;
    logic              mmix_write;
    logic [63:0]       mmix_writedata;
    logic [63:0]       mmix_readdata;
    logic              mmix_done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    mmix_avm_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mmix_address      (mmix_address),
        .mmix_datasize     (mmix_datasize),
        .mmix_read         (mmix_read),
        .mmix_write        (mmix_write),
        .mmix_writedata    (mmix_writedata),
        .mmix_readdata     (mmix_readdata),
        .mmix_done         (mmix_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } beat_t;

    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       exp_q[$];
    logic [7:0]  mmem [bit [31:0]];
    logic [7:0]  smem [bit [31:0]];
    logic [63:0] model_rd = 64'd0;

    int          cfg_wait = 0;
    int          cfg_rdly = 0;
    int          n_accepts = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [3:0]  last_be = 4'd0;

    bit          s_busy = 1'b0;
    int          s_wcnt = 0;
    logic [31:0] s_addr;
    logic [5:0]  s_ctl;
    logic [31:0] s_wd;
    bit          p_valid = 1'b0;
    int          p_cnt = 0;
    logic [31:0] p_data = 32'd0;
    beat_t       s_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] m_get(input logic [31:0] a);
        if (mmem.exists(a)) return mmem[a];
        return def_byte(a);
    endfunction

    function automatic logic [7:0] s_get(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return def_byte(a);
    endfunction

    task automatic poke(input logic [31:0] t, input logic [31:0] v);
        for (int j = 0; j < 4; j++) begin
            mmem[t + 32'(j)] = v[31-8*j -: 8];
            smem[t + 32'(j)] = v[31-8*j -: 8];
        end
    endtask

    // Reference model: an access covers 2^size bytes at the size-aligned address,
    // most significant byte at the lowest address.
    task automatic plan(input logic [31:0] a32, input int sz, input bit is_rd,
                        input logic [63:0] wd, output int ntet);
        int          n;
        int          i;
        logic [31:0] al;
        logic [31:0] t;
        logic [63:0] v;
        beat_t       e;
        n     = 1 << sz;
        al    = a32 & ~32'(n - 1);
        ntet  = (n == 8) ? 2 : 1;
        for (int k = 0; k < ntet; k++) begin
            t       = (al & ~32'd3) + 32'(4 * k);
            e.addr  = t;
            e.wr    = !is_rd;
            e.be    = 4'd0;
            e.wdata = 32'd0;
            e.wmask = 32'd0;
            for (int j = 0; j < 4; j++) begin
                if (t + 32'(j) >= al && t + 32'(j) < al + 32'(n)) begin
                    i = int'(t + 32'(j) - al);
                    e.be[3-j]              = 1'b1;
                    e.wdata[31-8*j -: 8]   = 8'(wd >> (8 * (n - 1 - i)));
                    e.wmask[31-8*j -: 8]   = 8'hFF;
                end
            end
            exp_q.push_back(e);
        end
        if (is_rd) begin
            v = 64'd0;
            for (int b = 0; b < n; b++) v = (v << 8) | 64'(m_get(al + 32'(b)));
            model_rd = v;
        end else begin
            for (int b = 0; b < n; b++) mmem[al + 32'(b)] = 8'(wd >> (8 * (n - 1 - b)));
        end
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic do_txn(input string tag, input logic [63:0] a, input int sz,
                          input bit rd, input bit wr, input logic [63:0] wd,
                          input int w, input int d);
        int ntet;
        int lat;
        int cyc;
        bit done_seen;
        cfg_wait = w;
        cfg_rdly = d;
        plan(a[31:0], sz, rd, wd, ntet);
        lat = ntet * (w + 1) + (rd ? ntet * (d + 1) : 0);
        mmix_address   = a;
        mmix_datasize  = 2'(sz);
        mmix_read      = rd;
        mmix_write     = wr;
        mmix_writedata = wd;
        @(posedge clk); #1;
        // Captured values must win over whatever the CPU drives afterwards.
        mmix_address   = {$urandom, $urandom};
        mmix_writedata = {$urandom, $urandom};
        mmix_datasize  = 2'($urandom);
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            done_seen = mmix_done;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_rdata"}, mmix_readdata, model_rd);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 64'(mmix_done), 64'd0);
        mmix_read  = 1'b0;
        mmix_write = 1'b0;
        check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        $display("txn %s addr=%h size=%0d rd=%0b wr=%0b lat=%0d rdata=%h", tag, a, sz, rd, wr, cyc, mmix_readdata);
    endtask

    // Avalon slave: decides waitrequest and drives read responses on the falling edge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (p_valid) begin
                if (p_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = p_data;
                    p_valid           = 1'b0;
                end else begin
                    p_cnt--;
                end
            end
            if (!reset_n) begin
                s_busy          = 1'b0;
                avm_waitrequest = 1'b0;
            end else if (avm_read || avm_write) begin
                if (!s_busy) begin
                    s_busy = 1'b1;
                    s_wcnt = cfg_wait;
                    s_addr = avm_address;
                    s_ctl  = {avm_read, avm_write, avm_byteenable};
                    s_wd   = avm_writedata;
                end else begin
                    check("cmd_hold_addr", 64'(avm_address), 64'(s_addr));
                    check("cmd_hold_ctl_wd", {avm_read, avm_write, avm_byteenable, avm_writedata}, {s_ctl, s_wd});
                end
                if (s_wcnt > 0) begin
                    avm_waitrequest = 1'b1;
                    s_wcnt--;
                end else begin
                    avm_waitrequest = 1'b0;
                    s_busy          = 1'b0;
                    n_accepts++;
                    prev_addr = last_addr;
                    last_addr = avm_address;
                    last_be   = avm_byteenable;
                    n_cmp++;
                    assert (exp_q.size() > 0) else begin
                        n_err++;
                        $error("FAIL unexpected_beat observed addr=%h expected no beat", avm_address);
                    end
                    if (exp_q.size() > 0) begin
                        s_e = exp_q.pop_front();
                        check("beat_addr", 64'(avm_address), 64'(s_e.addr));
                        check("beat_dir", {avm_read, avm_write}, s_e.wr ? 64'd1 : 64'd2);
                        check("beat_be", 64'(avm_byteenable), 64'(s_e.be));
                        if (s_e.wr) check("beat_wdata", 64'(avm_writedata & s_e.wmask), 64'(s_e.wdata));
                    end
                    if (avm_write) begin
                        last_wdata = avm_writedata;
                        for (int j = 0; j < 4; j++)
                            if (avm_byteenable[3-j]) smem[avm_address + 32'(j)] = avm_writedata[31-8*j -: 8];
                    end else begin
                        p_valid = 1'b1;
                        p_cnt   = cfg_rdly;
                        for (int j = 0; j < 4; j++) p_data[31-8*j -: 8] = s_get(avm_address + 32'(j));
                    end
                end
            end else begin
                avm_waitrequest = 1'($urandom);
                s_busy          = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int ntet;
        int cyc;
        int sz;
        bit rd;
        bit wr;
        reset_n        = 1'b0;
        mmix_address   = 64'd0;
        mmix_datasize  = 2'd0;
        mmix_read      = 1'b0;
        mmix_write     = 1'b0;
        mmix_writedata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl_addr", {mmix_done, avm_read, avm_write, avm_byteenable, avm_address}, 64'd0);
        check("reset_rdata", mmix_readdata, 64'd0);
        check("reset_wdata", 64'(avm_writedata), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        poke(32'h1000, 32'hAABBCCDD);
        do_txn("byte_rd", 64'h1003, 0, 1'b1, 1'b0, 64'd0, 0, 0);
        check("byte_rd_addr", 64'(last_addr), 64'h1000);
        check("byte_rd_be", 64'(last_be), 64'b0001);
        check("byte_rd_val", mmix_readdata, 64'h00000000000000DD);

        do_txn("wyde_wr", 64'h2002, 1, 1'b0, 1'b1, 64'h1234, 0, 0);
        check("wyde_wr_be", 64'(last_be), 64'b0011);
        check("wyde_wr_wd", 64'(last_wdata), 64'h12341234);
        check("wyde_wr_rdata_kept", mmix_readdata, 64'h00000000000000DD);

        poke(32'h3000, 32'h01234567);
        poke(32'h3004, 32'h89ABCDEF);
        do_txn("octa_rd", 64'h3005, 3, 1'b1, 1'b0, 64'd0, 0, 0);
        check("octa_rd_addr_hi", 64'(prev_addr), 64'h3000);
        check("octa_rd_addr_lo", 64'(last_addr), 64'h3004);
        check("octa_rd_val", mmix_readdata, 64'h0123456789ABCDEF);

        do_txn("tetra_wr_ws3", 64'h5001, 2, 1'b0, 1'b1, 64'hCAFEF00D_DEADBEEF, 3, 0);
        check("tetra_wr_wd", 64'(last_wdata), 64'hDEADBEEF);

        do_txn("octa_wr", 64'h5006, 3, 1'b0, 1'b1, 64'h1122334455667788, 0, 0);
        do_txn("both_strobes", 64'h2000, 2, 1'b1, 1'b1, 64'h55, 0, 1);
        do_txn("readback", 64'h5004, 2, 1'b1, 1'b0, 64'd0, 1, 2);

        // Reset while the LO beat of an octa read is waiting for its data.
        poke(32'h4000, 32'h0BADF00D);
        poke(32'h4004, 32'h600DCAFE);
        cfg_wait = 0;
        cfg_rdly = 4;
        base = n_accepts;
        plan(32'h4000, 3, 1'b1, 64'd0, ntet);
        mmix_address  = 64'h4000;
        mmix_datasize = 2'd3;
        mmix_read     = 1'b1;
        cyc = 0;
        while (n_accepts < base + 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid_reach_lo", 64'(n_accepts - base), 64'd2);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_ctl_addr", {mmix_done, avm_read, avm_write, avm_byteenable, avm_address}, 64'd0);
        check("rst_mid_rdata", mmix_readdata, 64'd0);
        check("rst_mid_wdata", 64'(avm_writedata), 64'd0);
        mmix_read = 1'b0;
        exp_q.delete();
        model_rd = 64'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {avm_read, avm_write, mmix_done}, 64'd0);
            check("post_rst_rdata", mmix_readdata, 64'd0);
        end
        $display("txn reset_mid_octa_rd accepts=%0d", n_accepts - base);

        for (int k = 0; k < 40; k++) begin
            sz = int'($urandom_range(0, 3));
            rd = 1'($urandom);
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            do_txn("rand", {$urandom, 32'h1000 + 32'($urandom_range(0, 63))}, sz, rd, wr,
                   {$urandom, $urandom}, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
